lif_neuron_mc: RTL

Parametrised multi-input leaky integrate-and-fire neuron, the next generation of the team's single-input LIF. It adds N_IN weighted synapses with signed (inhibitory) weights, programmable threshold and bias, and a saturating membrane. It also adds a configurable shift leak, a refractory period, selectable post-spike reset, and a spike counter. It sits between the input encoder and the spike router; one instance per neuron, advancing one timestep per in_valid strobe.

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_synapse_sum.sv | 34 +++
 rtl/lif_neuron_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and widths for the multi-input leaky integrate-and-fire neuron.
package lif_pkg;

  typedef enum logic [0:0] {
    LIF_INTEG,
    LIF_REFRAC
  } lif_state_e;

  localparam int unsigned LIF_CUR_W = 8;
  localparam int unsigned LIF_WGT_W = 8;

  // 9b unsigned-as-signed current times 8b signed weight fits in 17 bits; the
  // extra clog2 bits absorb the growth of the N-way sum.
  function automatic int unsigned lif_sum_w(input int unsigned n_in);
    return 17 + $clog2(n_in);
  endfunction

endpackage

// File: rtl/lif_synapse_sum.sv
// Combinational signed sum of all synaptic current*weight products.
module lif_synapse_sum
  import lif_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  localparam int unsigned SumW = lif_sum_w(N_IN)
) (
  input  logic [LIF_CUR_W*N_IN-1:0] current,
  input  logic [LIF_WGT_W*N_IN-1:0] weight,
  output logic signed [SumW-1:0]    syn_sum
);

  logic signed [SumW-1:0] cur_ext [N_IN];
  logic signed [SumW-1:0] wgt_ext [N_IN];
  logic signed [SumW-1:0] prod    [N_IN];
  logic signed [SumW-1:0] acc;

  for (genvar i = 0; i < N_IN; i++) begin : g_prod
    assign cur_ext[i] = {{(SumW-LIF_CUR_W){1'b0}}, current[i*LIF_CUR_W +: LIF_CUR_W]};
    assign wgt_ext[i] = {{(SumW-LIF_WGT_W){weight[i*LIF_WGT_W+LIF_WGT_W-1]}},
                         weight[i*LIF_WGT_W +: LIF_WGT_W]};
    assign prod[i]    = cur_ext[i] * wgt_ext[i];
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      acc = acc + prod[i];
    end
  end

  assign syn_sum = acc;

endmodule

// File: rtl/lif_neuron_mc.sv
// Multi-input LIF neuron: weighted synapses, shift leak, saturating membrane,
// refractory period, selectable post-spike reset and a saturating spike counter.
module lif_neuron_mc
  import lif_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned MEM_W      = 16,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC_CYC = 2,
  parameter int unsigned RESET_MODE = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [LIF_CUR_W*N_IN-1:0] current,
  input  logic [LIF_WGT_W*N_IN-1:0] weight,
  input  logic [MEM_W-1:0]          bias,
  input  logic [MEM_W-1:0]          thresh,
  input  logic                      clr_cnt,
  output logic                      spike,
  output logic [MEM_W-1:0]          membrane,
  output logic                      refractory,
  output logic [CNT_W-1:0]          spike_count
);

  localparam int unsigned SumW  = lif_sum_w(N_IN);
  // Three terms, each below 2^max in magnitude, plus a sign bit.
  localparam int unsigned FullW = ((MEM_W > SumW) ? MEM_W : SumW) + 3;
  localparam int unsigned RefW  = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

  lif_state_e              state_q, state_d;
  logic [MEM_W-1:0]        v_q, v_d;
  logic                    spike_q, spike_d;
  logic [RefW-1:0]         refr_q, refr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic signed [SumW-1:0]  syn;
  logic [MEM_W-1:0]        leaked;
  logic signed [FullW-1:0] s_full;
  logic [MEM_W-1:0]        vc;
  logic                    fire;
  logic                    integrate;

  lif_synapse_sum #(
    .N_IN(N_IN)
  ) u_syn (
    .current(current),
    .weight (weight),
    .syn_sum(syn)
  );

  assign leaked = v_q - (v_q >> LEAK_SHIFT);
  assign s_full = $signed({{(FullW-MEM_W){1'b0}}, leaked})
                + $signed({{(FullW-MEM_W){bias[MEM_W-1]}}, bias})
                + $signed({{(FullW-SumW){syn[SumW-1]}}, syn});

  always_comb begin
    if (s_full[FullW-1]) begin
      vc = '0;
    end else if (|s_full[FullW-2:MEM_W]) begin
      vc = '1;
    end else begin
      vc = s_full[MEM_W-1:0];
    end
  end

  assign fire      = (vc >= thresh);
  assign integrate = in_valid && (state_q == LIF_INTEG);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LIF_INTEG;
      refr_q  <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      refr_q  <= refr_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    refr_d  = refr_q;
    if (in_valid) begin
      unique case (state_q)
        LIF_INTEG: begin
          if (fire && (REFRAC_CYC > 0)) begin
            state_d = LIF_REFRAC;
            refr_d  = RefW'(REFRAC_CYC);
          end
        end
        LIF_REFRAC: begin
          refr_d = refr_q - RefW'(1);
          if (refr_q == RefW'(1)) begin
            state_d = LIF_INTEG;
          end
        end
        default: state_d = LIF_INTEG;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    v_d     = v_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    if (integrate) begin
      if (fire) begin
        spike_d = 1'b1;
        v_d     = (RESET_MODE != 0) ? (vc - thresh) : '0;
      end else begin
        v_d = vc;
      end
    end
    // Clear wins over the old value, but a simultaneous spike still counts.
    if (clr_cnt) begin
      cnt_d = '0;
    end
    if (spike_d && (cnt_d != '1)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    spike       = spike_q;
    membrane    = v_q;
    refractory  = (state_q == LIF_REFRAC);
    spike_count = cnt_q;
  end

endmodule
